rtl_kernel_wizard_0_example_number_checker: RTL

RTL_KERNEL_WIZARD_0_EXAMPLE_NUMBER_CHECKER -- requirements
Module: rtl_kernel_wizard_0_example_number_checker

---
 rtl/rtl_kernel_wizard_0_example_number_checker_pkg.sv | 57 +++++
 rtl/rtl_kernel_wizard_0_example_counter.sv | 35 +++
 rtl/rtl_kernel_wizard_0_example_number_checker.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/rtl_kernel_wizard_0_example_number_checker_pkg.sv
// Shared types and derivation helpers for the number-checker kernel example.
// The helpers derive the stream geometry from the top-level parameters.
//   N           : lanes per beat (data width / number width)
//   S           : lane-index bits (clog2 N, 0 for a single lane)
//   NUM_BEATS   : beats in one transfer (length rounded up to whole beats)
//   FINAL_TKEEP : byte-enable mask expected on the last beat
// The DEF_* localparams give the values for the default configuration.
package rtl_kernel_wizard_0_example_number_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Width of the beat index counters and of beat_count / first_err_beat.
    localparam int BEAT_W = 32;

    // Widest tkeep supported by calc_final_tkeep (1024-bit stream).
    localparam int MAX_KEEP_W = 128;

    function automatic int calc_lanes(input int data_w, input int num_w);
        return data_w / num_w;
    endfunction

    function automatic int calc_shift(input int lanes);
        return (lanes <= 1) ? 0 : $clog2(lanes);
    endfunction

    function automatic int calc_num_beats(input int len, input int data_w);
        int bpb;
        bpb = data_w / 8;
        return (len + bpb - 1) / bpb;
    endfunction

    // Low (len mod bytes-per-beat) bytes set when the tail beat is partial,
    // otherwise a full beat of ones.
    function automatic logic [MAX_KEEP_W-1:0] calc_final_tkeep(input int len, input int data_w);
        int bpb;
        int tail;
        logic [MAX_KEEP_W-1:0] keep;
        bpb  = data_w / 8;
        tail = len % bpb;
        keep = '0;
        for (int i = 0; i < MAX_KEEP_W; i++) begin
            if ((tail == 0 && i < bpb) || (i < tail)) keep[i] = 1'b1;
        end
        return keep;
    endfunction

    localparam int DEF_N         = calc_lanes(128, 32);
    localparam int DEF_S         = calc_shift(DEF_N);
    localparam int DEF_NUM_BEATS = calc_num_beats(16384, 128);
    localparam logic [15:0] DEF_FINAL_TKEEP = 16'(calc_final_tkeep(16384, 128));

endpackage

// File: rtl/rtl_kernel_wizard_0_example_counter.sv
// Generic up/down counter with synchronous reset and load.
//   clk        : clock
//   clken      : clock enable for load/incr/decr
//   rst        : synchronous active-high reset to C_INIT (ignores clken)
//   load       : load load_value (priority over incr/decr)
//   incr, decr : count up / down; both together hold
//   load_value : value for load
//   count      : current count
module rtl_kernel_wizard_0_example_counter #(
    parameter int                 C_WIDTH = 4,
    parameter logic [C_WIDTH-1:0] C_INIT  = '0
) (
    input  logic               clk,
    input  logic               clken,
    input  logic               rst,
    input  logic               load,
    input  logic               incr,
    input  logic               decr,
    input  logic [C_WIDTH-1:0] load_value,
    output logic [C_WIDTH-1:0] count
);

    localparam logic [C_WIDTH-1:0] ONE = C_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= C_INIT;
        end else if (clken) begin
            if (load)              count <= load_value;
            else if (incr & ~decr) count <= count + ONE;
            else if (~incr & decr) count <= count - ONE;
        end
    end

endmodule

// File: rtl/rtl_kernel_wizard_0_example_number_checker.sv
// AXI4-Stream checker for the kernel-wizard example number generator.
// After an ap_start rising edge it accepts one transfer, compares every beat
// against the generator pattern (lane k of beat b = {b, k}), and reports a
// sticky error flag, a saturating per-beat error count, the accepted beat
// count and the index of the first bad beat. Comparison results are
// registered for one cycle before being folded into the outputs.
//   aclk, areset       : clock, synchronous active-high reset
//   ap_start           : start request (rising edge while idle)
//   ap_done, ap_idle   : one-cycle completion pulse, idle indicator
//   s_axis_*           : input stream (tvalid/tready/tdata/tkeep/tlast)
//   error              : sticky mismatch flag
//   error_count        : erroneous beats, saturating
//   beat_count         : accepted beats
//   first_err_beat     : beat index of the first erroneous beat
module rtl_kernel_wizard_0_example_number_checker
    import rtl_kernel_wizard_0_example_number_checker_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = 128,
    parameter int C_NUMBER_BIT_WIDTH   = 32,
    parameter int C_LENGTH_IN_BYTES    = 16384,
    parameter int C_ERR_CNT_WIDTH      = 16,
    parameter int C_THROTTLE           = 0
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic                              ap_start,
    output logic                              ap_done,
    output logic                              ap_idle,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                              s_axis_tlast,
    output logic                              error,
    output logic [C_ERR_CNT_WIDTH-1:0]        error_count,
    output logic [31:0]                       beat_count,
    output logic [31:0]                       first_err_beat
);

    localparam int N         = calc_lanes(C_S_AXIS_TDATA_WIDTH, C_NUMBER_BIT_WIDTH);
    localparam int S         = calc_shift(N);
    localparam int NUM_BEATS = calc_num_beats(C_LENGTH_IN_BYTES, C_S_AXIS_TDATA_WIDTH);
    localparam int KEEP_W    = C_S_AXIS_TDATA_WIDTH / 8;
    localparam int CNT_W     = C_NUMBER_BIT_WIDTH - S;

    localparam logic [KEEP_W-1:0] FINAL_TKEEP =
        KEEP_W'(calc_final_tkeep(C_LENGTH_IN_BYTES, C_S_AXIS_TDATA_WIDTH));
    localparam logic [BEAT_W-1:0]          LAST_IDX = BEAT_W'(NUM_BEATS - 1);
    localparam logic [C_ERR_CNT_WIDTH-1:0] ERR_ONE  = C_ERR_CNT_WIDTH'(1);

    state_t state, state_nxt;

    logic                            ap_start_r;
    logic [1:0]                      thr_cnt;
    logic                            stall;
    logic                            start_edge;
    logic                            hs;
    logic                            last_beat;
    logic                            beat_end;
    logic [BEAT_W-1:0]               exp_beat;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] exp_data;
    logic [KEEP_W-1:0]               exp_keep;
    logic [KEEP_W-1:0]               byte_bad;
    logic                            beat_err;

    // single compare stage
    logic              vld_pipe;
    logic              err_pipe;
    logic [BEAT_W-1:0] beat_pipe;

    // ---------------------------------------------------------------- control

    assign start_edge = (state == IDLE) & ap_start & ~ap_start_r;

    // free-running phase for optional backpressure: every 4th cycle stalls
    assign stall         = (C_THROTTLE != 0) && (thr_cnt == 2'd3);
    assign s_axis_tready = (state == RUN) & ~stall;
    assign ap_idle       = (state == IDLE);
    assign ap_done       = (state == DONE);

    assign hs        = s_axis_tvalid & s_axis_tready;
    assign last_beat = (exp_beat == LAST_IDX);
    // an early tlast also closes the transfer
    assign beat_end  = hs & (last_beat | s_axis_tlast);

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= IDLE;
            ap_start_r <= 1'b0;
            thr_cnt    <= 2'd0;
        end else begin
            state      <= state_nxt;
            ap_start_r <= ap_start;
            thr_cnt    <= thr_cnt + 2'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_edge) state_nxt = RUN;
            RUN:     if (beat_end)   state_nxt = FLUSH;
            FLUSH:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // index of the beat currently expected
    rtl_kernel_wizard_0_example_counter #(
        .C_WIDTH (BEAT_W),
        .C_INIT  ('0)
    ) u_beat_cnt (
        .clk        (aclk),
        .clken      (1'b1),
        .rst        (start_edge | areset),
        .load       (1'b0),
        .incr       (hs),
        .decr       (1'b0),
        .load_value ('0),
        .count      (exp_beat)
    );

    // ---------------------------------------------------------------- compare

    for (genvar k = 0; k < N; k++) begin : g_lane
        if (S == 0) begin : g_one
            assign exp_data[k*C_NUMBER_BIT_WIDTH +: C_NUMBER_BIT_WIDTH] = CNT_W'(exp_beat);
        end else begin : g_many
            // counter field wraps; lane index fills the low bits
            assign exp_data[k*C_NUMBER_BIT_WIDTH +: C_NUMBER_BIT_WIDTH] = {CNT_W'(exp_beat), S'(k)};
        end
    end

    assign exp_keep = last_beat ? FINAL_TKEEP : {KEEP_W{1'b1}};

    // bytes outside the expected keep are don't-care even if the sender enables them
    for (genvar j = 0; j < KEEP_W; j++) begin : g_byte
        assign byte_bad[j] = s_axis_tkeep[j] & exp_keep[j] &
                             (s_axis_tdata[j*8 +: 8] != exp_data[j*8 +: 8]);
    end

    assign beat_err = (|byte_bad) | (s_axis_tkeep != exp_keep) | (s_axis_tlast != last_beat);

    always_ff @(posedge aclk) begin
        if (areset) begin
            vld_pipe  <= 1'b0;
            err_pipe  <= 1'b0;
            beat_pipe <= '0;
        end else begin
            vld_pipe  <= hs;
            err_pipe  <= hs & beat_err;
            beat_pipe <= exp_beat;
        end
    end

    // ---------------------------------------------------------------- results

    always_ff @(posedge aclk) begin
        if (areset || start_edge) begin
            error          <= 1'b0;
            error_count    <= '0;
            beat_count     <= '0;
            first_err_beat <= '0;
        end else if (vld_pipe) begin
            beat_count <= beat_count + 32'd1;
            if (err_pipe) begin
                if (error_count != {C_ERR_CNT_WIDTH{1'b1}}) error_count <= error_count + ERR_ONE;
                if (!error) begin
                    error          <= 1'b1;
                    first_err_beat <= beat_pipe;
                end
            end
        end
    end

endmodule
